wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback-side consumer for the M5/WB, ALU-WB and MEM-WB pipeline registers: collects up to N_SRC completed results per cycle and forwards exactly one per cycle to the reorder buffer write port. Losing sources receive `stall` so their WB register holds its contents until granted. Round-robin arbitration bounds the wait of any valid source to N_SRC-1 grants.

## Interface
- N_SRC, 3, number of writeback producers (index 0 = ALU, 1 = MEM, 2 = MUL)
- WORD_SIZE, 32, result / pc width
- INSTR_TYPE_SZ, 3, instruction type width
- ROB_ENTRY_WIDTH, 3, ROB index width
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- src_valid  in  N_SRC  producer i holds a completed result
- src_instr_type  in  N_SRC*INSTR_TYPE_SZ  packed, slice i = producer i
- src_pc  in  N_SRC*WORD_SIZE  packed
- src_result  in  N_SRC*WORD_SIZE  packed
- src_rob_id  in  N_SRC*ROB_ENTRY_WIDTH  packed
- src_stall  out  N_SRC  combinational hold request to producer i
- rob_wr_ready  in  1  ROB can accept a write this cycle
- rob_wr_valid  out  1  registered write strobe
- rob_wr_type  out  INSTR_TYPE_SZ  registered
- rob_wr_pc  out  WORD_SIZE  registered
- rob_wr_value  out  WORD_SIZE  registered
- rob_wr_id  out  ROB_ENTRY_WIDTH  registered
- grant_idx  out  clog2(N_SRC)  registered index of source written this cycle (debug/perf)

## Operation
- State: round-robin pointer `rr_ptr` (0..N_SRC-1), output register set.
- Grant (combinational): if rob_wr_ready=1, grant the first i with src_valid[i]=1 scanning rr_ptr, rr_ptr+1, … modulo N_SRC; else no grant.
- src_stall[i] = src_valid[i] & ~grant[i]. Invalid sources never see stall=1.
- On a grant to g at posedge: output registers load slice g, rob_wr_valid=1, grant_idx=g, rr_ptr = (g+1) mod N_SRC.
- No grant at posedge: rob_wr_valid=0, data/id/grant_idx outputs hold previous values, rr_ptr unchanged.
- rob_wr_ready=0: all valid sources stalled; no state change except rob_wr_valid=0.
- A stalled source must keep valid and payload stable; arbiter does not latch losing payloads.
- Single valid source with ready: granted immediately, no stall, regardless of rr_ptr.
- Pointer wrap: g = N_SRC-1 sets rr_ptr=0.
- Duplicate rob_id from two sources in one cycle is a producer error; arbiter still serialises them, no check.

## Timing
- Latency: source payload at posedge k (valid, granted) appears on rob_wr_* after posedge k, i.e. usable cycle k+1; one write per cycle max.
- src_stall is combinational from src_valid, rob_wr_ready, rr_ptr; sampled by producers at the same posedge.
- Reset (synchronous, priority over everything): rr_ptr=0, rob_wr_valid=0, rob_wr_type=0, rob_wr_pc=0, rob_wr_value=0, rob_wr_id=0, grant_idx=0. src_stall during reset cycle = 0 (grants suppressed); a result presented during reset is not written and is not held for the producer.
- Reset mid-stream: in-flight rob_wr_valid drops to 0 the cycle after reset is sampled.
- Worst-case wait for a continuously valid source: N_SRC-1 cycles with rob_wr_ready=1.

## Structure
- WORD_SIZE, INSTR_TYPE_SZ, ROB_ENTRY_WIDTH, N_SRC defaults and source-index constants (SRC_ALU, SRC_MEM, SRC_MUL) live in the shared defines/package.
- One sub-module: `rr_arbiter` (N-way round-robin, inputs req/ptr/enable, outputs one-hot grant and encoded index); wb_arbiter owns rr_ptr, muxing and output registers.

## Test plan
- Reset: assert reset with src_valid=3'b111 -> rob_wr_valid=0, all outputs 0, src_stall=0; release -> first grant to source 0.
- Single source: only src_valid[1]=1, result=0xDEADBEEF, rob_id=5 -> next cycle rob_wr_valid=1, value=0xDEADBEEF, id=5, grant_idx=1, src_stall=0.
- Full contention: src_valid=3'b111 held, producers advance on no-stall -> grants 0,1,2,0,1,2 on consecutive cycles, each source stalled ≤2 cycles.
- Back-pressure: src_valid=3'b101, rob_wr_ready=0 for 3 cycles -> src_stall=3'b101, rob_wr_valid=0, rr_ptr unchanged; ready=1 -> grant to source at rr_ptr.
- Wrap: rr_ptr=2, src_valid=3'b101 -> grant 2, then 0; rr_ptr returns to 0 then 1.
- Reset mid-stream: reset asserted while rob_wr_valid=1 -> next cycle rob_wr_valid=0, rr_ptr=0, pending sources not written.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, source indices and helpers for the writeback arbiter
package wb_arbiter_pkg;

    localparam int WORD_SIZE       = 32;
    localparam int INSTR_TYPE_SZ   = 3;
    localparam int ROB_ENTRY_WIDTH = 3;
    localparam int N_SRC           = 3;

    // Writeback producer slots in the packed source vectors
    localparam int SRC_ALU = 0;
    localparam int SRC_MEM = 1;
    localparam int SRC_MUL = 2;

    // Index width for an n-way selector; a single source still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// rtl/wb_arbiter_rr_arbiter.sv - N-way round-robin grant selector starting at a supplied pointer
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N     = N_SRC,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    int unsigned cand;

    // Walk requesters from ptr upward modulo N; the first one found wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (enable && !grant_any && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - forwards one completed writeback result per cycle to the ROB write port
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_SRC           = wb_arbiter_pkg::N_SRC,
    parameter int WORD_SIZE       = wb_arbiter_pkg::WORD_SIZE,
    parameter int INSTR_TYPE_SZ   = wb_arbiter_pkg::INSTR_TYPE_SZ,
    parameter int ROB_ENTRY_WIDTH = wb_arbiter_pkg::ROB_ENTRY_WIDTH,
    parameter int IDX_W           = idx_width(N_SRC)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [N_SRC-1:0]                   src_valid,
    input  logic [N_SRC*INSTR_TYPE_SZ-1:0]     src_instr_type,
    input  logic [N_SRC*WORD_SIZE-1:0]         src_pc,
    input  logic [N_SRC*WORD_SIZE-1:0]         src_result,
    input  logic [N_SRC*ROB_ENTRY_WIDTH-1:0]   src_rob_id,
    output logic [N_SRC-1:0]                   src_stall,
    input  logic                               rob_wr_ready,
    output logic                               rob_wr_valid,
    output logic [INSTR_TYPE_SZ-1:0]           rob_wr_type,
    output logic [WORD_SIZE-1:0]               rob_wr_pc,
    output logic [WORD_SIZE-1:0]               rob_wr_value,
    output logic [ROB_ENTRY_WIDTH-1:0]         rob_wr_id,
    output logic [IDX_W-1:0]                   grant_idx
);

    logic [IDX_W-1:0]           rr_ptr;
    logic [N_SRC-1:0]           grant;
    logic [IDX_W-1:0]           sel_idx;
    logic                       grant_any;
    logic [IDX_W-1:0]           next_ptr;
    logic [INSTR_TYPE_SZ-1:0]   sel_type;
    logic [WORD_SIZE-1:0]       sel_pc;
    logic [WORD_SIZE-1:0]       sel_result;
    logic [ROB_ENTRY_WIDTH-1:0] sel_id;

    // Grants are suppressed during reset so nothing presented then is written
    rr_arbiter #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req       (src_valid),
        .ptr       (rr_ptr),
        .enable    (rob_wr_ready & ~reset),
        .grant     (grant),
        .grant_idx (sel_idx),
        .grant_any (grant_any)
    );

    // Losers hold their WB register; during reset nothing is held either
    always_comb begin
        src_stall = reset ? '0 : (src_valid & ~grant);
    end

    // One-hot payload mux with constant slice offsets
    always_comb begin
        sel_type   = '0;
        sel_pc     = '0;
        sel_result = '0;
        sel_id     = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant[i]) begin
                sel_type   = src_instr_type[i*INSTR_TYPE_SZ +: INSTR_TYPE_SZ];
                sel_pc     = src_pc[i*WORD_SIZE +: WORD_SIZE];
                sel_result = src_result[i*WORD_SIZE +: WORD_SIZE];
                sel_id     = src_rob_id[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
            end
        end
    end

    // Pointer moves just past the winner, wrapping from the last source to 0
    always_comb begin
        next_ptr = (sel_idx == IDX_W'(N_SRC-1)) ? '0 : sel_idx + IDX_W'(1);
    end

    // Output register set and round-robin pointer; payload holds when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            rob_wr_valid <= 1'b0;
            rob_wr_type  <= '0;
            rob_wr_pc    <= '0;
            rob_wr_value <= '0;
            rob_wr_id    <= '0;
            grant_idx    <= '0;
        end else begin
            rob_wr_valid <= grant_any;
            if (grant_any) begin
                rr_ptr       <= next_ptr;
                rob_wr_type  <= sel_type;
                rob_wr_pc    <= sel_pc;
                rob_wr_value <= sel_result;
                rob_wr_id    <= sel_id;
                grant_idx    <= sel_idx;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  src_valid;
    logic [8:0]  src_instr_type;
    logic [95:0] src_pc;
    logic [95:0] src_result;
    logic [8:0]  src_rob_id;
    logic [2:0]  src_stall;
    logic        rob_wr_ready;
    logic        rob_wr_valid;
    logic [2:0]  rob_wr_type;
    logic [31:0] rob_wr_pc;
    logic [31:0] rob_wr_value;
    logic [2:0]  rob_wr_id;
    logic [1:0]  grant_idx;

    logic [2:0]  typ [3];
    logic [31:0] pc  [3];
    logic [31:0] res [3];
    logic [2:0]  rid [3];

    assign src_instr_type = {typ[2], typ[1], typ[0]};
    assign src_pc         = {pc[2], pc[1], pc[0]};
    assign src_result     = {res[2], res[1], res[0]};
    assign src_rob_id     = {rid[2], rid[1], rid[0]};

    wb_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .src_valid      (src_valid),
        .src_instr_type (src_instr_type),
        .src_pc         (src_pc),
        .src_result     (src_result),
        .src_rob_id     (src_rob_id),
        .src_stall      (src_stall),
        .rob_wr_ready   (rob_wr_ready),
        .rob_wr_valid   (rob_wr_valid),
        .rob_wr_type    (rob_wr_type),
        .rob_wr_pc      (rob_wr_pc),
        .rob_wr_value   (rob_wr_value),
        .rob_wr_id      (rob_wr_id),
        .grant_idx      (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the ROB port should show, and whose turn is next
    int          m_next;
    logic        m_valid;
    logic [2:0]  m_type;
    logic [31:0] m_pc;
    logic [31:0] m_val;
    logic [2:0]  m_id;
    int          m_gidx;
    int          last_g;
    int          wait_cnt [3];
    bit          rand_mode;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The valid source closest at or after the turn pointer (cyclic distance) wins
    function automatic int ref_grant(input logic [2:0] v, input bit rdy, input bit rst, input int turn);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = 99;
        if (rst || !rdy) return -1;
        for (int i = 0; i < 3; i++) begin
            if (v[i]) begin
                d = (i - turn + 3) % 3;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic new_payload(input int i);
        typ[i] = 3'($urandom);
        pc[i]  = $urandom;
        res[i] = $urandom;
        rid[i] = 3'($urandom);
    endtask

    // One clock: check stall before the edge, advance model, check ROB outputs after
    task automatic do_cycle();
        int         g;
        logic [2:0] exp_stall;
        #1;
        g = ref_grant(src_valid, rob_wr_ready, reset, m_next);
        exp_stall = reset ? 3'b000 : src_valid;
        if (g >= 0) exp_stall[g] = 1'b0;
        chk("src_stall", 64'(src_stall), 64'(exp_stall));
        if (rand_mode && !reset && rob_wr_ready) begin
            for (int i = 0; i < 3; i++) begin
                if (exp_stall[i]) begin
                    wait_cnt[i]++;
                    chk("wait_bound", 64'(wait_cnt[i] <= 2), 64'(1));
                end else begin
                    wait_cnt[i] = 0;
                end
            end
        end
        @(posedge clk);
        if (reset) begin
            m_next = 0; m_valid = 1'b0; m_type = '0; m_pc = '0; m_val = '0; m_id = '0; m_gidx = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1; m_type = typ[g]; m_pc = pc[g]; m_val = res[g]; m_id = rid[g];
            m_gidx  = g;
            m_next  = (g + 1) % 3;
        end else begin
            m_valid = 1'b0;
        end
        last_g = g;
        #1;
        chk("rob_wr_valid", 64'(rob_wr_valid), 64'(m_valid));
        chk("rob_wr_type",  64'(rob_wr_type),  64'(m_type));
        chk("rob_wr_pc",    64'(rob_wr_pc),    64'(m_pc));
        chk("rob_wr_value", 64'(rob_wr_value), 64'(m_val));
        chk("rob_wr_id",    64'(rob_wr_id),    64'(m_id));
        chk("grant_idx",    64'(grant_idx),    64'(m_gidx));
        // Granted producers move on to a fresh result; stalled ones hold
        if (g >= 0) new_payload(g);
        if (rand_mode) begin
            for (int i = 0; i < 3; i++) begin
                if (i == g) begin
                    src_valid[i] = 1'($urandom);
                end else if (!src_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    new_payload(i);
                    src_valid[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rand_mode = 1'b0;
        m_next = 0; m_valid = 1'b0; m_type = '0; m_pc = '0; m_val = '0; m_id = '0; m_gidx = 0;
        last_g = -1;
        for (int i = 0; i < 3; i++) begin
            wait_cnt[i] = 0;
            new_payload(i);
        end
        reset        = 1'b1;
        src_valid    = 3'b111;
        rob_wr_ready = 1'b1;
        @(negedge clk);

        // Reset with all sources valid: nothing stalled, nothing written
        do_cycle();
        do_cycle();
        chk("reset_valid", 64'(rob_wr_valid), 64'(0));
        chk("reset_value", 64'(rob_wr_value), 64'(0));
        reset = 1'b0;
        do_cycle();
        chk("first_grant", 64'(grant_idx), 64'(0));

        // Single source on MEM, regardless of pointer
        src_valid = 3'b010;
        res[1] = 32'hDEADBEEF;
        rid[1] = 3'd5;
        do_cycle();
        chk("single_value", 64'(rob_wr_value), 64'h0000_0000_DEAD_BEEF);
        chk("single_id",    64'(rob_wr_id),    64'(5));
        chk("single_gidx",  64'(grant_idx),    64'(1));

        // Full contention from a clean pointer: strict 0,1,2 rotation
        reset = 1'b1;
        do_cycle();
        reset = 1'b0;
        src_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            do_cycle();
            chk("rotate_gidx",  64'(grant_idx),    64'(k % 3));
            chk("rotate_valid", 64'(rob_wr_valid), 64'(1));
        end

        // Back-pressure: everything valid stalls, no write, pointer frozen at 0
        src_valid = 3'b101;
        rob_wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_cycle();
            chk("bp_valid", 64'(rob_wr_valid), 64'(0));
        end
        rob_wr_ready = 1'b1;
        do_cycle();
        chk("bp_release_gidx", 64'(grant_idx), 64'(0));

        // Wrap: steer pointer to 2, then 3'b101 must go 2 then 0
        src_valid = 3'b010;
        do_cycle();
        src_valid = 3'b101;
        do_cycle();
        chk("wrap_first",  64'(grant_idx), 64'(2));
        do_cycle();
        chk("wrap_second", 64'(grant_idx), 64'(0));
        src_valid = 3'b111;
        do_cycle();
        chk("wrap_after",  64'(grant_idx), 64'(1));

        // Reset mid-stream drops the write strobe and restarts at source 0
        reset = 1'b1;
        do_cycle();
        chk("midrst_valid", 64'(rob_wr_valid), 64'(0));
        reset = 1'b0;
        do_cycle();
        chk("midrst_gidx",  64'(grant_idx), 64'(0));

        // Randomized traffic with occasional back-pressure and reset
        rand_mode = 1'b1;
        for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
        for (int k = 0; k < 400; k++) begin
            rob_wr_ready = ($urandom_range(0, 9) < 8);
            reset        = ($urandom_range(0, 49) == 0);
            if (reset) begin
                for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
            end
            do_cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
